// File: rtl/fft_agu_pipe_pkg.sv
// Shared types, default sizes and the bit-reverse helper for the FFT address generator.
package fft_pkg;

   localparam int M_DEFAULT      = 9;
   localparam int BF_LAT_DEFAULT = 3;
   localparam int ADR_W          = M_DEFAULT;
   localparam int TW_W           = M_DEFAULT - 1;
   localparam int LOG2N_W        = $clog2(M_DEFAULT + 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      LVL_WAIT,
      DRAIN,
      DONE
   } state_e;

   // Reverses the low nbits of v; bits at and above nbits come out zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input logic [31:0] nbits);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (32'(i) < nbits) begin
            r[i] = v[5'(nbits - 32'(i) - 32'd1)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_agu_pipe_adrcalc.sv
// Combinational radix-2 butterfly address and twiddle index generation.
module fft_agu_pipe_adrcalc
   import fft_pkg::*;
#(
   parameter int M  = M_DEFAULT,
   parameter int NW = $clog2(M + 1),
   parameter int IW = M - 1
) (
   input  logic [NW-1:0] level,
   input  logic [IW-1:0] index,
   output logic [M-1:0]  adr_a,
   output logic [M-1:0]  adr_b,
   output logic [IW-1:0] tw
);

   logic [M-1:0] idx_w;
   logic [M-1:0] span;
   logic [M-1:0] low;

   // A inserts a zero at bit L of the index, B sets that bit.
   always_comb begin
      idx_w = M'(index);
      span  = M'(1) << level;
      low   = idx_w & (span - M'(1));
      adr_a = ((idx_w >> level) << (32'(level) + 32'd1)) | low;
      adr_b = adr_a + span;
      tw    = IW'(low << (M - 1 - 32'(level)));
   end

endmodule

// File: rtl/fft_agu_pipe.sv
// In-place FFT address generator: level/index FSM, write-back delay line, load counter.
// Optional FFT_AGU_BITREV_EN makes ld_adr bit-reversed over log2n bits.
module fft_agu_pipe
   import fft_pkg::*;
#(
   parameter int M      = M_DEFAULT,
   parameter int BF_LAT = BF_LAT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [$clog2(M+1)-1:0]   log2n,
   input  logic                     stall,
   input  logic                     ld_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     rd_en,
   output logic                     rd_sel,
   output logic [M-1:0]             adr_A,
   output logic [M-1:0]             adr_B,
   output logic [M-2:0]             twiddle_adr,
   output logic                     we0,
   output logic                     we1,
   output logic [M-1:0]             wr_adr_A,
   output logic [M-1:0]             wr_adr_B,
   output logic                     res_sel,
   output logic [M-1:0]             ld_adr
);

   localparam int NW = $clog2(M + 1);
   localparam int IW = M - 1;
   localparam int CW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

   state_e        state_q, state_d;
   logic [NW-1:0] n_q, n_d;
   logic [NW-1:0] level_q, level_d;
   logic [IW-1:0] index_q, index_d;
   logic [CW-1:0] wait_q, wait_d;
   logic          err_q, err_d;
   logic [M-1:0]  ld_cnt_q, ld_cnt_d;

   logic          issue;
   logic          start_ok;
   logic [IW-1:0] last_idx;
   logic [M-1:0]  ld_mask;
   logic [M-1:0]  ld_adr_raw;
   logic [M-1:0]  adr_a_raw, adr_b_raw;
   logic [IW-1:0] tw_raw;

   fft_agu_pipe_adrcalc #(
      .M  (M),
      .NW (NW),
      .IW (IW)
   ) u_adrcalc (
      .level (level_q),
      .index (index_q),
      .adr_a (adr_a_raw),
      .adr_b (adr_b_raw),
      .tw    (tw_raw)
   );

   always_comb begin
      last_idx = IW'((32'd1 << (n_q - NW'(1))) - 32'd1);
      ld_mask  = (n_q == '0) ? '1 : M'((32'd1 << n_q) - 32'd1);
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      level_d  = level_q;
      index_d  = index_q;
      wait_d   = wait_q;
      err_d    = 1'b0;
      issue    = 1'b0;
      start_ok = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (log2n != '0 && 32'(log2n) <= M) begin
                  start_ok = 1'b1;
                  state_d  = RUN;
                  n_d      = log2n;
                  level_d  = '0;
                  index_d  = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!stall) begin
               issue = 1'b1;
               if (index_q == last_idx) begin
                  index_d = '0;
                  wait_d  = CW'(BF_LAT - 1);
                  state_d = (level_q == n_q - NW'(1)) ? DRAIN : LVL_WAIT;
               end else begin
                  index_d = index_q + IW'(1);
               end
            end
         end
         LVL_WAIT: begin
            if (wait_q == '0) begin
               state_d = RUN;
               level_d = level_q + NW'(1);
            end else begin
               wait_d = wait_q - CW'(1);
            end
         end
         DRAIN: begin
            if (wait_q == '0) begin
               state_d = DONE;
            end else begin
               wait_d = wait_q - CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ld_cnt_d = ld_cnt_q;
      if (start_ok) begin
         ld_cnt_d = '0;
      end else if (ld_valid) begin
         ld_cnt_d = (ld_cnt_q + M'(1)) & ld_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         n_q      <= '0;
         level_q  <= '0;
         index_q  <= '0;
         wait_q   <= '0;
         err_q    <= 1'b0;
         ld_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         level_q  <= level_d;
         index_q  <= index_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         ld_cnt_q <= ld_cnt_d;
      end
   end

   // Write-back pipe mirrors the butterfly latency and shifts every cycle, stall or not.
   genvar gi;
   generate
      for (gi = 0; gi < BF_LAT; gi++) begin : g_dl
         logic         vld_q;
         logic         bank_q;
         logic [M-1:0] a_q;
         logic [M-1:0] b_q;
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) begin
                  vld_q <= 1'b0;
               end else begin
                  vld_q <= issue;
               end
               bank_q <= ~level_q[0];
               a_q    <= adr_a_raw;
               b_q    <= adr_b_raw;
            end
         end else begin : g_tail
            always_ff @(posedge clk) begin
               if (reset) begin
                  vld_q <= 1'b0;
               end else begin
                  vld_q <= g_dl[gi-1].vld_q;
               end
               bank_q <= g_dl[gi-1].bank_q;
               a_q    <= g_dl[gi-1].a_q;
               b_q    <= g_dl[gi-1].b_q;
            end
         end
      end
   endgenerate

`ifdef FFT_AGU_BITREV_EN
   always_comb ld_adr_raw = M'(bitrev(32'(ld_cnt_q), 32'(n_q)));
`else
   always_comb ld_adr_raw = ld_cnt_q;
`endif

   logic run;
   logic wr_vld;

   // Outputs are forced low while reset is held so in-flight writes never leak out.
   always_comb begin
      run         = !reset && (state_q == RUN);
      wr_vld      = !reset && g_dl[BF_LAT-1].vld_q;
      busy        = !reset && (state_q == RUN || state_q == LVL_WAIT || state_q == DRAIN);
      done        = !reset && (state_q == DONE);
      err         = !reset && err_q;
      rd_en       = run && !stall;
      rd_sel      = !reset && level_q[0];
      adr_A       = run ? adr_a_raw : '0;
      adr_B       = run ? adr_b_raw : '0;
      twiddle_adr = run ? tw_raw : '0;
      we0         = wr_vld && !g_dl[BF_LAT-1].bank_q;
      we1         = wr_vld && g_dl[BF_LAT-1].bank_q;
      wr_adr_A    = wr_vld ? g_dl[BF_LAT-1].a_q : '0;
      wr_adr_B    = wr_vld ? g_dl[BF_LAT-1].b_q : '0;
      res_sel     = !reset && n_q[0];
      ld_adr      = reset ? '0 : ld_adr_raw;
   end

endmodule

// File: tb/tb_fft_agu_pipe.sv
// Self-checking bench for fft_agu_pipe (M=9, BF_LAT=3): case table plus scoreboard monitor.
module tb_fft_agu_pipe;

   localparam int M  = 9;
   localparam int BL = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] log2n = 4'd0;
   logic       stall = 1'b0;
   logic       ld_valid = 1'b0;

   logic       busy, done, err, rd_en, rd_sel, we0, we1, res_sel;
   logic [8:0] adr_A, adr_B, wr_adr_A, wr_adr_B, ld_adr;
   logic [7:0] twiddle_adr;

   always #5 clk = ~clk;

   fft_agu_pipe #(.M(M), .BF_LAT(BL)) dut (
      .clk(clk), .reset(reset), .start(start), .log2n(log2n), .stall(stall),
      .ld_valid(ld_valid), .busy(busy), .done(done), .err(err), .rd_en(rd_en),
      .rd_sel(rd_sel), .adr_A(adr_A), .adr_B(adr_B), .twiddle_adr(twiddle_adr),
      .we0(we0), .we1(we1), .wr_adr_A(wr_adr_A), .wr_adr_B(wr_adr_B),
      .res_sel(res_sel), .ld_adr(ld_adr)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int m_n = 0, m_level = 0, m_idx = 0;
   int first_cyc = 0, done_cyc = 0, wr_cnt = 0, pend0 = 0, pend1 = 0;
   bit first_seen = 0, done_seen = 0;

   typedef struct {
      int   due;
      logic bank;
      int   a;
      int   b;
   } wr_t;
   wr_t wq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: predicts each butterfly's addresses and its write BL cycles later.
   always @(negedge clk) begin
      wr_t w;
      logic ewe0, ewe1;
      int ea, eb, etw, span, low;
      cyc++;
      if (reset) begin
         wq.delete();
         pend0 = 0;
         pend1 = 0;
         chk("reset_outs", {busy, done, err, rd_en, rd_sel, we0, we1, res_sel,
                            |adr_A, |adr_B, |twiddle_adr, |wr_adr_A, |wr_adr_B, |ld_adr}, 0);
      end else begin
         ewe0 = 0; ewe1 = 0; ea = 0; eb = 0;
         if (wq.size() > 0 && wq[0].due == cyc) begin
            w = wq.pop_front();
            ewe0 = !w.bank;
            ewe1 = w.bank;
            ea = w.a;
            eb = w.b;
         end
         chk("wr", {we0, we1, wr_adr_A, wr_adr_B}, {ewe0, ewe1, 9'(ea), 9'(eb)});
         if (rd_en) begin
            chk("hazard", rd_sel ? pend1 : pend0, 0);
         end
         if (we0) pend0--;
         if (we1) pend1--;
         wr_cnt += int'(we0) + int'(we1);
         if (rd_en) begin
            if (m_n == 0) begin
               chk("rd_unexpected", 1, 0);
            end else begin
               span = 1 << m_level;
               low  = m_idx % span;
               ea   = (m_idx / span) * 2 * span + low;
               eb   = ea + span;
               etw  = low * (1 << (M - 1 - m_level));
               chk("rd", {rd_sel, adr_A, adr_B, twiddle_adr},
                   {1'(m_level % 2), 9'(ea), 9'(eb), 8'(etw)});
               w.due  = cyc + BL;
               w.bank = !(m_level % 2);
               w.a    = ea;
               w.b    = eb;
               wq.push_back(w);
               if (w.bank) pend1++; else pend0++;
               if (!first_seen) begin
                  first_seen = 1;
                  first_cyc  = cyc;
               end
               m_idx++;
               if (m_idx == (1 << (m_n - 1))) begin
                  m_idx = 0;
                  m_level++;
               end
            end
         end
         if (!busy) begin
            chk("idle_adr", {rd_en, adr_A, adr_B, twiddle_adr}, 0);
         end
         if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int n);
      m_n = n; m_level = 0; m_idx = 0;
      first_seen = 0; done_seen = 0; wr_cnt = 0;
      start = 1'b1;
      log2n = 4'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 6000 && !done_seen; k++) tick();
      chk("done_seen", done_seen, 1);
   endtask

   typedef struct {
      int n;
      bit exp_err;
      int stall_at;
      int stall_len;
      int exp_off;
   } case_t;
   case_t tbl[8];
   int exp_ld[8];

   initial begin
      tbl[0] = '{2,  0, 0, 0,  10};
      tbl[1] = '{1,  0, 0, 0,   4};
      tbl[2] = '{0,  1, 0, 0,   0};
      tbl[3] = '{10, 1, 0, 0,   0};
      tbl[4] = '{3,  0, 0, 0,  21};
      tbl[5] = '{9,  0, 0, 0, 2331};
      tbl[6] = '{5,  0, 5, 10, 105};
      tbl[7] = '{15, 1, 0, 0,   0};
`ifdef FFT_AGU_BITREV_EN
      exp_ld = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
      exp_ld = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

      repeat (3) tick();
      reset = 1'b0;
      tick();

      for (int c = 0; c < 8; c++) begin
         do_start(tbl[c].n);
         if (tbl[c].exp_err) begin
            chk("err_pulse", err, 1);
            chk("busy_rej", busy, 0);
            tick();
            chk("err_once", err, 0);
            chk("busy_rej2", busy, 0);
            $display("case %0d: log2n=%0d rejected", c, tbl[c].n);
         end else begin
            chk("busy_start", busy, 1);
            chk("err_acc", err, 0);
            if (tbl[c].stall_len > 0) begin
               repeat (tbl[c].stall_at) tick();
               stall = 1'b1;
               repeat (tbl[c].stall_len) tick();
               stall = 1'b0;
               tick();
               start = 1'b1;
               log2n = 4'd2;
               tick();
               start = 1'b0;
            end
            wait_done();
            chk("done_off", done_cyc - first_cyc, tbl[c].exp_off);
            chk("wr_cnt", wr_cnt, tbl[c].n * (1 << (tbl[c].n - 1)));
            tick();
            chk("busy_end", busy, 0);
            chk("res_sel", res_sel, tbl[c].n % 2);
            $display("case %0d: log2n=%0d stall=%0d done_offset=%0d writes=%0d",
                     c, tbl[c].n, tbl[c].stall_len, done_cyc - first_cyc, wr_cnt);
         end
         repeat (2) tick();
      end

      // Reset while draining: pending writes and the done pulse must vanish.
      do_start(2);
      repeat (8) tick();
      chk("drain_busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_idle", {busy, done, we0, we1}, 0);
      repeat (20) tick();
      chk("no_done", done_seen, 0);
      $display("reset in DRAIN: busy=%0d done_seen=%0d", busy, done_seen);

      // Load address sequence over one 8-point frame, then wrap.
      do_start(3);
      for (int i = 0; i < 8; i++) begin
         chk("ld_adr", ld_adr, exp_ld[i]);
         $display("load %0d: ld_adr=%0d", i, ld_adr);
         ld_valid = 1'b1;
         tick();
         ld_valid = 1'b0;
      end
      chk("ld_wrap", ld_adr, 0);
      wait_done();
      chk("ld_done_off", done_cyc - first_cyc, 21);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_agu_pipe.md
FFT_AGU_PIPE -- requirements
Module: fft_agu_pipe

Interface
REQ-001 SHALL have parameter M, default 9, meaning log2 of the maximum FFT length.
REQ-002 SHALL have parameter BF_LAT, default 3, meaning butterfly pipeline latency in cycles (>=1).
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin a transform; sampled only in IDLE.
REQ-007 log2n  in  $clog2(M+1)  runtime length exponent; sampled on accepted start.
REQ-008 stall  in  1  suppress butterfly issue this cycle.
REQ-009 ld_valid  in  1  one input sample written this cycle.
REQ-010 busy  out  1  transform in progress.
REQ-011 done  out  1  one-cycle pulse, transform complete.
REQ-012 err  out  1  one-cycle pulse, start rejected.
REQ-013 rd_en  out  1  butterfly issued.
REQ-014 rd_sel  out  1  bank read this level.
REQ-015 adr_A, adr_B  out  M  read addresses.
REQ-016 twiddle_adr  out  M-1  twiddle ROM address.
REQ-017 we0, we1  out  1  write enable for bank 0 and bank 1.
REQ-018 wr_adr_A, wr_adr_B  out  M  write-back addresses.
REQ-019 res_sel  out  1  bank holding the final result (= latched n[0]).
REQ-020 ld_adr  out  M  load address for the current input sample.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, LVL_WAIT, DRAIN, DONE.
REQ-022 IDLE->RUN on start with 1<=log2n<=M: latch n, zero level and index, assert busy.
REQ-023 Start with log2n==0 or log2n>M SHALL stay in IDLE and pulse err.
REQ-024 Start outside IDLE SHALL be ignored.
REQ-025 RUN, stall=0: assert rd_en and issue one butterfly; index steps 0..2^(n-1)-1.
REQ-026 RUN, stall=1: rd_en=0; level and index hold.
REQ-027 On the last index of level L<n-1: go to LVL_WAIT for exactly BF_LAT cycles, then RUN with level L+1, index 0.
REQ-028 On the last index of level n-1: go to DRAIN for BF_LAT cycles, then DONE.
REQ-029 stall SHALL be ignored in LVL_WAIT and DRAIN.
REQ-030 DONE: pulse done for one cycle, deassert busy, return to IDLE.
REQ-031 Address calculation, with span=2^L: adr_A=((index>>L)<<(L+1))|(index&(span-1)), adr_B=adr_A+span, twiddle_adr=(index&(span-1))<<(M-1-L); unused upper bits SHALL be zero.
REQ-032 rd_sel=level[0]; the write bank SHALL be ~level[0] of the issuing level.
REQ-033 Each issued butterfly's {valid, adr_A, adr_B, write bank} SHALL be delayed exactly BF_LAT cycles to we0/we1/wr_adr_A/wr_adr_B.
REQ-034 The delay line SHALL advance every cycle regardless of stall.
REQ-035 With no stalls, done SHALL pulse at offset n*(2^(n-1)+BF_LAT) cycles after the first rd_en.
REQ-036 ld_cnt SHALL increment on ld_valid, wrap at 2^log2n, and clear on reset and on accepted start.
REQ-037 Outside RUN, rd_en=0 and adr_A, adr_B, twiddle_adr=0.

Reset
REQ-038 Reset in any state SHALL return to IDLE and clear level, index, ld_cnt and all delay-line valids.
REQ-039 Reset SHALL hold every output at 0, including in-flight writes.

Configuration
REQ-040 With FFT_AGU_BITREV_EN defined, ld_adr SHALL be the bit-reverse of the low log2n bits of ld_cnt, with upper bits zero.
REQ-041 With FFT_AGU_BITREV_EN undefined, ld_adr SHALL equal ld_cnt.

Structure
REQ-042 Package fft_pkg SHALL hold the FSM state enum, the address-width constants and the bit-reverse function.
REQ-043 Address calculation SHALL live in combinational sub-module fft_agu_pipe_adrcalc; the FSM and delay line SHALL live in the top module.

Verification
REQ-044 M=9, BF_LAT=1, start with log2n=2 -> (A,B,tw) = (0,1,0), (2,3,0), then (0,2,0), (1,3,128); rd_sel 0 then 1; res_sel=0.
REQ-045 M=9, BF_LAT=3, log2n=9, no stall -> done pulses at offset 2331 after the first rd_en; exactly 2304 write enables; never a read of a bank within BF_LAT cycles of its last write.
REQ-046 stall high for 10 cycles mid-level -> done delayed exactly 10 cycles; address sequence unchanged.
REQ-047 log2n=0 or 10 with M=9 -> err pulse; busy stays 0; start while busy -> no effect.
REQ-048 Reset asserted during DRAIN -> next cycle IDLE, we0=we1=0, done never pulses.
REQ-049 FFT_AGU_BITREV_EN defined, log2n=3, 8 ld_valid -> ld_adr = 0,4,2,6,1,5,3,7; undefined -> 0..7.
